// File: rtl/writeback_pkg.sv
// Shared widths and the register-file write request type for the writeback stage.
package writeback_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    localparam logic [REG_AW-1:0] R7_ADDR = 3'd7;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/writeback_if.sv
// Pipeline-facing bundle of the writeback stage: ALU/load inputs, R7 update, RF write outputs.
interface writeback_if
    import writeback_pkg::*;
#(
    parameter int LD_DEPTH = 4
) ();

    localparam int LCW = $clog2(LD_DEPTH) + 1;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              ld_issue;
    logic [REG_AW-1:0] ld_dest;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              set_r7;
    logic [DATA_W-1:0] r7_value;

    logic              wren;
    logic [REG_AW-1:0] write_addr;
    logic [DATA_W-1:0] new_reg;
    logic [DATA_W-1:0] r7;
    logic              stall;
    logic [LCW-1:0]    ld_pending;
    logic              err;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output ld_issue, ld_dest,
        output mem_rvalid, mem_rdata,
        output set_r7, r7_value,
        input  wren, write_addr, new_reg, r7, stall, ld_pending, err
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  ld_issue, ld_dest,
        input  mem_rvalid, mem_rdata,
        input  set_r7, r7_value,
        output wren, write_addr, new_reg, r7, stall, ld_pending, err
    );

endinterface

// File: rtl/writeback_sync_fifo.sv
// Small synchronous FIFO with show-ahead head; push while full is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/writeback.sv
// Register-file write side: merges in-order load returns with ALU results, one RF write per cycle, owns R7.
module writeback
    import writeback_pkg::*;
#(
    parameter int LD_DEPTH = 4,
    parameter int Q_DEPTH  = 2
) (
    input  logic       clk,
    input  logic       rst,
    writeback_if.slave bus
);

    localparam int LCW = $clog2(LD_DEPTH) + 1;
    localparam int QCW = $clog2(Q_DEPTH) + 1;

    logic [REG_AW-1:0] tag_head;
    logic              tag_full;
    logic              tag_empty;
    logic [LCW-1:0]    tag_count;

    wr_req_t           hold_head;
    wr_req_t           hold_din;
    logic              hold_full;
    logic              hold_empty;
    logic [QCW-1:0]    hold_count;

    logic              ld_pop;
    logic              hold_pop;
    logic              alu_bypass;
    logic              alu_enq;
    logic              win_valid;
    wr_req_t           win;
    logic              win_rf;
    logic              win_r7;
    logic              err_set;

    logic              wren_q;
    logic [REG_AW-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] r7_q;
    logic              err_q;

    sync_fifo #(
        .WIDTH (REG_AW),
        .DEPTH (LD_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.ld_issue),
        .pop   (bus.mem_rvalid),
        .din   (bus.ld_dest),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    sync_fifo #(
        .WIDTH ($bits(wr_req_t)),
        .DEPTH (Q_DEPTH)
    ) u_hold_q (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_enq),
        .pop   (hold_pop),
        .din   (hold_din),
        .dout  (hold_head),
        .full  (hold_full),
        .empty (hold_empty),
        .count (hold_count)
    );

    assign ld_pop = bus.mem_rvalid & ~tag_empty;

    // Load returns cannot be back-pressured, so they always win; queued ALU results drain before any bypass.
    always_comb begin
        win_valid  = 1'b0;
        win        = '0;
        hold_pop   = 1'b0;
        alu_bypass = 1'b0;
        if (ld_pop) begin
            win_valid = 1'b1;
            win.dest  = tag_head;
            win.data  = bus.mem_rdata;
        end else if (!hold_empty) begin
            win_valid = 1'b1;
            win       = hold_head;
            hold_pop  = 1'b1;
        end else if (bus.alu_valid) begin
            win_valid  = 1'b1;
            win.dest   = bus.alu_dest;
            win.data   = bus.alu_data;
            alu_bypass = 1'b1;
        end
    end

    assign alu_enq  = bus.alu_valid & ~alu_bypass;
    assign hold_din = '{dest: bus.alu_dest, data: bus.alu_data};

    assign win_r7 = win_valid & (win.dest == R7_ADDR);
    assign win_rf = win_valid & (win.dest != R7_ADDR);

    assign err_set = (bus.ld_issue & tag_full & ~ld_pop)
                   | (bus.mem_rvalid & tag_empty)
                   | (alu_enq & hold_full & ~hold_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            r7_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            wren_q <= win_rf;
            if (win_rf) begin
                addr_q <= win.dest;
                data_q <= win.data;
            end
            // set_r7 comes from a younger instruction than any retiring write.
            if (bus.set_r7) begin
                r7_q <= bus.r7_value;
            end else if (win_r7) begin
                r7_q <= win.data;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    assign bus.wren       = wren_q;
    assign bus.write_addr = addr_q;
    assign bus.new_reg    = data_q;
    assign bus.r7         = r7_q;
    assign bus.err        = err_q;
    assign bus.ld_pending = tag_count;
    assign bus.stall      = (tag_count == LCW'(LD_DEPTH)) | (hold_count == QCW'(Q_DEPTH));

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: bypass, load ordering, collisions, R7 routing, full/error, reset mid-flight.
module tb_writeback;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    writeback_if #(.LD_DEPTH(4)) bus ();

    writeback #(
        .LD_DEPTH (4),
        .Q_DEPTH  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid  = 1'b0;
        bus.alu_dest   = '0;
        bus.alu_data   = '0;
        bus.ld_issue   = 1'b0;
        bus.ld_dest    = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.set_r7     = 1'b0;
        bus.r7_value   = '0;
    endtask

    task automatic check_wr(input string tag, input logic wren, input logic [2:0] addr, input logic [15:0] data);
        check_eq({tag, "_wren"}, 32'(bus.wren), 32'(wren));
        check_eq({tag, "_addr"}, 32'(bus.write_addr), 32'(addr));
        check_eq({tag, "_data"}, 32'(bus.new_reg), 32'(data));
    endtask

    task automatic check_reset_state(input string tag);
        check_wr(tag, 1'b0, 3'd0, 16'h0000);
        check_eq({tag, "_r7"}, 32'(bus.r7), 32'h0);
        check_eq({tag, "_stall"}, 32'(bus.stall), 32'h0);
        check_eq({tag, "_pend"}, 32'(bus.ld_pending), 32'h0);
        check_eq({tag, "_err"}, 32'(bus.err), 32'h0);
    endtask

    logic [2:0]  drain_dest [4];
    logic [15:0] drain_data [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drain_dest = '{3'd1, 3'd2, 3'd3, 3'd6};
        drain_data = '{16'hC001, 16'hC002, 16'hC003, 16'hC006};
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check_reset_state("reset");
        rst = 1'b0;

        // ALU bypass
        bus.alu_valid = 1'b1; bus.alu_dest = 3'd3; bus.alu_data = 16'h1234;
        step();
        idle_inputs();
        check_wr("bypass", 1'b1, 3'd3, 16'h1234);
        step();
        check_wr("bypass_after", 1'b0, 3'd3, 16'h1234);

        // Load ordering
        bus.ld_issue = 1'b1; bus.ld_dest = 3'd2;
        step();
        check_eq("ld_pend1", 32'(bus.ld_pending), 32'd1);
        bus.ld_dest = 3'd5;
        step();
        check_eq("ld_pend2", 32'(bus.ld_pending), 32'd2);
        idle_inputs();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'hAAAA;
        step();
        check_wr("ld_ret1", 1'b1, 3'd2, 16'hAAAA);
        check_eq("ld_pend3", 32'(bus.ld_pending), 32'd1);
        bus.mem_rdata = 16'hBBBB;
        step();
        check_wr("ld_ret2", 1'b1, 3'd5, 16'hBBBB);
        check_eq("ld_pend4", 32'(bus.ld_pending), 32'd0);
        idle_inputs();

        // Load return collides with ALU result
        bus.ld_issue = 1'b1; bus.ld_dest = 3'd4;
        step();
        idle_inputs();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h0F0F;
        bus.alu_valid  = 1'b1; bus.alu_dest  = 3'd1; bus.alu_data = 16'h0001;
        step();
        idle_inputs();
        check_wr("coll_ld", 1'b1, 3'd4, 16'h0F0F);
        check_eq("coll_stall1", 32'(bus.stall), 32'd0);
        step();
        check_wr("coll_alu", 1'b1, 3'd1, 16'h0001);
        check_eq("coll_stall2", 32'(bus.stall), 32'd0);
        step();
        check_eq("coll_idle", 32'(bus.wren), 32'd0);

        // R7 routing
        bus.alu_valid = 1'b1; bus.alu_dest = 3'd7; bus.alu_data = 16'h00FF;
        step();
        idle_inputs();
        check_eq("r7_alu_wren", 32'(bus.wren), 32'd0);
        check_eq("r7_alu_val", 32'(bus.r7), 32'h00FF);
        bus.alu_valid = 1'b1; bus.alu_dest = 3'd7; bus.alu_data = 16'h1111;
        bus.set_r7    = 1'b1; bus.r7_value = 16'hAB00;
        step();
        idle_inputs();
        check_eq("r7_set_wren", 32'(bus.wren), 32'd0);
        check_eq("r7_set_val", 32'(bus.r7), 32'hAB00);
        check_eq("r7_err", 32'(bus.err), 32'd0);

        // Tag FIFO full, overflow, push+pop while full, drain
        for (int i = 0; i < 4; i++) begin
            bus.ld_issue = 1'b1; bus.ld_dest = 3'(i);
            step();
            check_eq($sformatf("fill_pend%0d", i), 32'(bus.ld_pending), 32'(i + 1));
        end
        check_eq("full_stall", 32'(bus.stall), 32'd1);
        check_eq("full_err0", 32'(bus.err), 32'd0);
        bus.ld_dest = 3'd5;
        step();
        check_eq("ovf_err", 32'(bus.err), 32'd1);
        check_eq("ovf_pend", 32'(bus.ld_pending), 32'd4);
        bus.ld_dest = 3'd6; bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h5555;
        step();
        idle_inputs();
        check_wr("full_pushpop", 1'b1, 3'd0, 16'h5555);
        check_eq("full_pushpop_pend", 32'(bus.ld_pending), 32'd4);
        for (int i = 0; i < 4; i++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = drain_data[i];
            step();
            check_wr($sformatf("drain%0d", i), 1'b1, drain_dest[i], drain_data[i]);
        end
        check_eq("drain_pend", 32'(bus.ld_pending), 32'd0);
        check_eq("drain_stall", 32'(bus.stall), 32'd0);
        bus.mem_rdata = 16'hDEAD;
        step();
        idle_inputs();
        check_eq("under_wren", 32'(bus.wren), 32'd0);

        // Reset mid-flight: 2 loads pending and 1 queued ALU result
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst2_err", 32'(bus.err), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            bus.ld_issue = 1'b1; bus.ld_dest = 3'(i);
            step();
        end
        idle_inputs();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h4321;
        bus.alu_valid  = 1'b1; bus.alu_dest  = 3'd5; bus.alu_data = 16'h7777;
        step();
        idle_inputs();
        check_wr("mid_ld", 1'b1, 3'd1, 16'h4321);
        check_eq("mid_pend", 32'(bus.ld_pending), 32'd2);
        rst = 1'b1;
        step();
        check_reset_state("midrst");
        rst = 1'b0;
        step();
        check_eq("midrst_noq", 32'(bus.wren), 32'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 16'h9999;
        step();
        idle_inputs();
        check_eq("post_rst_err", 32'(bus.err), 32'd1);
        check_eq("post_rst_wren", 32'(bus.wren), 32'd0);
        check_eq("post_rst_pend", 32'(bus.ld_pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
